// File: rtl/mux_t_be_t_n.sv
// Temporal-match multiplexer for race-logic datapaths.
// Each output channel fires when any input's first event of the gamma cycle
// lands on that channel's select time. The output gamma trails the input
// gamma by two cycles and is rendered as a rising step, falling step or pulse.
module mux_t_be_t_n #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_INPUTS        = 16,
  parameter int NUM_CHANNELS      = 4,
  parameter int MODE              = 0,
  parameter int SELECT_WIDTH      = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic [NUM_INPUTS-1:0]                inputs,
  input  logic [NUM_CHANNELS*SELECT_WIDTH-1:0] select,
  output logic [SELECT_WIDTH-1:0]              phase,
  output logic                                 gamma_start,
  output logic [NUM_CHANNELS-1:0]              out,
  output logic [NUM_CHANNELS-1:0]              hit,
  output logic                                 hit_valid
);

  localparam logic [SELECT_WIDTH-1:0] LAST_PHASE = SELECT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [SELECT_WIDTH-1:0] PHASE_ONE  = SELECT_WIDTH'(1);
  localparam logic [NUM_CHANNELS-1:0] OUT_IDLE   = (MODE == 1) ? {NUM_CHANNELS{1'b1}}
                                                               : {NUM_CHANNELS{1'b0}};

  // Input side: edge detection and first-event suppression
  logic                                 first_phase;
  logic [NUM_INPUTS-1:0]                active;
  logic [NUM_INPUTS-1:0]                prev_active;
  logic [NUM_INPUTS-1:0]                fired;
  logic [NUM_INPUTS-1:0]                evt;

  // Stage 1 registers: was there any event, and at which tag
  logic                                 evt_q;
  logic [SELECT_WIDTH-1:0]              tag_q;
  logic [NUM_CHANNELS*SELECT_WIDTH-1:0] sel_q;

  // Output side
  logic [NUM_CHANNELS-1:0]              fire;
  logic [NUM_CHANNELS-1:0]              hit_acc;
  logic                                 out_start;

  assign first_phase = (phase == '0);
  assign gamma_start = first_phase;
  // The edge that closes the phase-1 cycle opens the next output gamma.
  assign out_start   = (phase == PHASE_ONE);

  // Per-input event: active now, inactive at the previous tag, not yet fired this gamma
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    active = (MODE == 1) ? ~inputs : inputs;
    evt    = '0;
    if (first_phase) evt = active;
    else             evt = active & ~prev_active & ~fired;
  end

  // Phase counter, input history, fired flags, stage-1 event/tag and select capture
  always_ff @(posedge aclk or posedge grst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (grst) begin
      phase       <= '0;
      prev_active <= '0;
      fired       <= '0;
      evt_q       <= 1'b0;
      tag_q       <= '0;
      sel_q       <= '0;
    end else begin
      phase       <= (phase == LAST_PHASE) ? '0 : phase + PHASE_ONE;
      prev_active <= active;
      fired       <= (first_phase ? '0 : fired) | evt;
      evt_q       <= |evt;
      tag_q       <= phase;
      if (first_phase) sel_q <= select;
    end
  end

  // Channel match: the stage-1 tag equals the captured select and an event occurred
  always_comb begin
    fire = '0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      fire[j] = evt_q && (tag_q == sel_q[j*SELECT_WIDTH +: SELECT_WIDTH]);
    end
  end

  // Hit summary: accumulate fires over an output gamma, publish at its boundary
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      hit_acc   <= '0;
      hit       <= '0;
      hit_valid <= 1'b0;
    end else begin
      hit_valid <= out_start;
      if (out_start) begin
        hit     <= hit_acc;
        hit_acc <= fire;
      end else begin
        hit_acc <= hit_acc | fire;
      end
    end
  end

  generate
    if (MODE == 2) begin : g_pulse
      localparam int               CNT_W      = $clog2(PULSE_WIDTH + 1);
      localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_WIDTH);
      localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

      logic [NUM_CHANNELS-1:0][CNT_W-1:0] cnt;
      logic [NUM_CHANNELS-1:0][CNT_W-1:0] cnt_next;

      // Remaining pulse cycles per channel; the output gamma boundary truncates
      always_comb begin
        cnt_next = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
          if (fire[j])                     cnt_next[j] = PULSE_LOAD;
          else if (out_start)              cnt_next[j] = '0;
          else if (cnt[j] != '0)           cnt_next[j] = cnt[j] - CNT_ONE;
          else                             cnt_next[j] = '0;
        end
      end

      // Pulse counters and the registered pulse output
      always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
          cnt <= '0;
          out <= OUT_IDLE;
        end else begin
          cnt <= cnt_next;
          for (int j = 0; j < NUM_CHANNELS; j++) out[j] <= (cnt_next[j] != '0);
        end
      end
    end else begin : g_step
      // Step output: restart at the output gamma boundary, then latch the fire
      always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
          out <= OUT_IDLE;
        end else if (MODE == 1) begin
          out <= (out_start ? OUT_IDLE : out) & ~fire;
        end else begin
          out <= (out_start ? OUT_IDLE : out) | fire;
        end
      end
    end
  endgenerate

endmodule

// File: doc/mux_t_be_t_n.md
# mux_t_be_t_n

Multi-channel, parametrised temporal-match multiplexer for the race-logic datapath. Inputs carry values encoded as event times within a gamma cycle of GAMMA_CYCLE_WIDTH aclk cycles. Each output channel has its own binary select time, and fires when any input's event coincides with that time. The encoding (rising step, falling step or pulse) is chosen by parameter, and a per-gamma hit summary is produced for the control plane.

## Interface
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (≥4)
- PULSE_WIDTH, 8, output pulse length in MODE 2 (≥1)
- NUM_INPUTS, 16, temporal input lines
- NUM_CHANNELS, 4, independent output channels
- MODE, 0, encoding: 0 rising step, 1 falling step, 2 pulse
- SELECT_WIDTH, $clog2(GAMMA_CYCLE_WIDTH), select field width
- aclk  input  1  clock
- grst  input  1  reset, asynchronous, active-high
- inputs  input  NUM_INPUTS  temporal inputs
- select  input  NUM_CHANNELS*SELECT_WIDTH  channel j select time at bits [j*SELECT_WIDTH +: SELECT_WIDTH]
- phase  output  SELECT_WIDTH  current input-side gamma phase
- gamma_start  output  1  high while phase==0
- out  output  NUM_CHANNELS  temporal channel outputs
- hit  output  NUM_CHANNELS  channels that fired in the last completed output gamma
- hit_valid  output  1  one-cycle strobe when hit updates

## Operation
- Phase counter: 0 after reset. Increments every aclk and wraps GAMMA_CYCLE_WIDTH-1→0. Inputs sampled in a cycle with phase==p carry time tag p.
- Active level: high for MODE 0/2, low for MODE 1.
- Event detection, per input:
  - The event time is the first tag p at which the sampled input is active and its previous sample is inactive.
  - At p==0 the previous sample is treated as inactive. An input already active at phase 0 therefore has event time 0.
  - A per-input fired flag, cleared at p==0, suppresses further events in the same gamma.
- Select: channel selects are captured on the edge that samples phase 0 and held for the whole gamma. Mid-gamma select changes are ignored. A select ≥ GAMMA_CYCLE_WIDTH never matches.
- Match: channel j fires at tag p when p == sel_j and at least one input has an event at p. A channel fires at most once per gamma. Multiple simultaneous matching inputs produce a single fire.
- Output gamma = input gamma delayed by LATENCY=2. It starts in the cycle where phase==2.
- Output encoding, per channel:
  - MODE 0: out rises on fire and holds 1 to the end of the output gamma. It returns to 0 at output gamma start.
  - MODE 1: out is 1 at output gamma start, drops to 0 on fire and holds low to the end of the output gamma.
  - MODE 2: out is high for PULSE_WIDTH cycles from fire. It is truncated at the output gamma boundary and never spans two gammas.
- Hit summary: per-channel fire flags accumulate over the output gamma. In the cycle with phase==2 they are transferred to hit, hit_valid pulses for 1 cycle, and the flags clear. hit holds its value until the next transfer.

## Timing
- Reset values: phase=0, gamma_start=1, out=0 (MODE 0/2) or all-ones (MODE 1), hit=0, hit_valid=0, all fired/match flags clear.
- Latency: an input event in the phase-p cycle produces an out change in the phase-(p+2 mod GAMMA) cycle.
- Events at p = GAMMA-2 or GAMMA-1 appear in phases 0/1, which still belong to the same output gamma.
- The first hit_valid after reset comes at the first phase==2 cycle. It reports all-zero hits, because that output gamma was partial.
- Reset mid-gamma:
  - Everything clears asynchronously.
  - The first edge after deassert starts a new gamma at phase 0.
  - Partial-gamma events are lost.
- All outputs are registered except gamma_start, which is decoded from the phase register.

## Test plan
- Reset check: grst mid-gamma → out=0 (MODE 0), phase=0, hit=0, hit_valid=0. After release, phase counts 0,1,2… and the first hit_valid occurs at phase 2.
- MODE 0, GAMMA=16, NUM_INPUTS=4, NUM_CHANNELS=2, inputs[2] rises at phase 5, sel0=5, sel1=6:
  - out[0] rises in the phase-7 cycle, stays high through phase 1 and falls at phase 2.
  - out[1] stays 0.
  - At that phase 2, hit=2'b01 and hit_valid=1 for one cycle.
- MODE 0, inputs[0] rises at 3, falls at 5 and rises again at 9; inputs[1] held high from the prior gamma; sel0=9, sel1=0 → out[0] never fires (inputs[0] event time is 3); out[1] fires at phase 2 (event time 0).
- Simultaneity: inputs[1] and inputs[3] both rise at phase 4, sel0=sel1=4 → out[0] and out[1] both rise in the phase-6 cycle, each exactly once. The next summary is hit=2'b11.
- MODE 1: out resets to 2'b11. inputs[0] falls at phase 4 with sel0=4 → out[0] drops in the phase-6 cycle and returns to 1 at the next phase 2. Changing sel0 to 7 at phase 3 has no effect in that gamma.
- MODE 2, PULSE_WIDTH=8, event at phase 12 with sel0=12 → out[0] is high in phases 14, 15, 0 and 1 only (truncated to 4 cycles), and low from phase 2.
